// File: rtl/irs2_pkg.sv
// Shared types and constants for the IRS2 Wilkinson test-oscillator servo.
package irs2_pkg;

  localparam int unsigned VDLY_W = 16;
  localparam int unsigned CNT_W  = 16;

  localparam logic [VDLY_W-1:0] VDLY_DEFAULT = 16'h8000;
  localparam logic [VDLY_W-1:0] VDLY_STEP    = 16'd16;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StStart,
    StCount,
    StUpdate
  } state_e;

endpackage

// File: rtl/irs2_tstout_sync.sv
// Two-flop synchronizer followed by a rising-edge pulse; usable for any IRS2 test output.
module irs2_tstout_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sig_i,
  output logic pulse_o
);

  // [0],[1] form the synchronizer, [2] holds the previous synchronized level.
  logic [2:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], sig_i};
    end
  end

  assign pulse_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/irs2_wilkinson_servo.sv
// Runs the IRS2 TSTCLR/TSTST sequence, counts TSTOUT edges per gate window and servos Vdly.
module irs2_wilkinson_servo
  import irs2_pkg::*;
#(
  parameter int unsigned       GATE_CYCLES  = 65536,
  parameter int unsigned       CLR_CYCLES   = 16,
  parameter logic [VDLY_W-1:0] VDLY_DEFAULT = irs2_pkg::VDLY_DEFAULT,
  parameter logic [VDLY_W-1:0] VDLY_STEP    = irs2_pkg::VDLY_STEP,
  parameter int unsigned       DEADBAND     = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              servo_en_i,
  input  logic [CNT_W-1:0]  target_i,
  input  logic              vdly_load_i,
  input  logic [VDLY_W-1:0] vdly_init_i,
  input  logic              tstout_i,
  output logic              tstclr_o,
  output logic              tstst_o,
  output logic [VDLY_W-1:0] vdly_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              count_valid_o,
  output logic              busy_o
);

  localparam int unsigned       TMR_W    = 25;
  localparam logic [TMR_W-1:0]  GateLast = TMR_W'(GATE_CYCLES - 1);
  localparam logic [TMR_W-1:0]  ClrLast  = TMR_W'(CLR_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CntMax   = '1;
  localparam logic [VDLY_W-1:0] VdlyMax  = '1;
  localparam logic signed [17:0] DbS     = 18'(DEADBAND);

  state_e            state_q, state_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [VDLY_W-1:0] vdly_q, vdly_d;
  logic [VDLY_W-1:0] vdly_up, vdly_dn;
  logic [VDLY_W:0]   vdly_sum;
  logic signed [17:0] cnt_s, lo_s, hi_s;
  logic              edge_p;

  irs2_tstout_sync u_tstout_sync (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .sig_i   (tstout_i),
    .pulse_o (edge_p)
  );

  assign cnt_inc = (edge_p && (cnt_q != CntMax)) ? cnt_q + 1'b1 : cnt_q;

  // Widened signed compare so target near 0 or 16'hFFFF cannot wrap.
  assign cnt_s = signed'({2'b00, count_q});
  assign lo_s  = signed'({2'b00, target_i}) - DbS;
  assign hi_s  = signed'({2'b00, target_i}) + DbS;

  assign vdly_sum = {1'b0, vdly_q} + {1'b0, VDLY_STEP};
  assign vdly_up  = vdly_sum[VDLY_W] ? VdlyMax : vdly_sum[VDLY_W-1:0];
  assign vdly_dn  = (vdly_q < VDLY_STEP) ? '0 : vdly_q - VDLY_STEP;

  always_comb begin
    state_d       = state_q;
    tmr_d         = tmr_q;
    cnt_d         = cnt_q;
    count_d       = count_q;
    vdly_d        = vdly_q;
    tstclr_o      = 1'b0;
    tstst_o       = 1'b0;
    busy_o        = 1'b1;
    count_valid_o = 1'b0;

    unique case (state_q)
      StIdle: begin
        tstclr_o = 1'b1;
        busy_o   = 1'b0;
        tmr_d    = '0;
        if (enable_i) state_d = StClear;
      end
      StClear: begin
        tstclr_o = 1'b1;
        tmr_d    = tmr_q + 1'b1;
        if (tmr_q == ClrLast) begin
          state_d = StStart;
          tmr_d   = '0;
        end
      end
      StStart: begin
        tstst_o = 1'b1;
        tmr_d   = tmr_q + 1'b1;
        if (tmr_q == ClrLast) begin
          state_d = StCount;
          tmr_d   = '0;
          cnt_d   = '0;
        end
      end
      StCount: begin
        cnt_d = cnt_inc;
        tmr_d = tmr_q + 1'b1;
        if (tmr_q == GateLast) begin
          state_d = StUpdate;
          tmr_d   = '0;
          count_d = cnt_inc;
        end
      end
      StUpdate: begin
        count_valid_o = 1'b1;
        tmr_d         = '0;
        if (servo_en_i) begin
          if (cnt_s < lo_s) begin
            vdly_d = vdly_up;
          end else if (cnt_s > hi_s) begin
            vdly_d = vdly_dn;
          end
        end
        state_d = enable_i ? StClear : StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Abort discards the partial window; count_o keeps the last completed value.
    if (!enable_i && (state_q inside {StClear, StStart, StCount})) begin
      state_d = StIdle;
      tmr_d   = '0;
      count_d = count_q;
    end

    if (vdly_load_i) vdly_d = vdly_init_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      tmr_q   <= '0;
      cnt_q   <= '0;
      count_q <= '0;
      vdly_q  <= VDLY_DEFAULT;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      cnt_q   <= cnt_d;
      count_q <= count_d;
      vdly_q  <= vdly_d;
    end
  end

  assign vdly_o  = vdly_q;
  assign count_o = count_q;

endmodule

// File: tb/tb_irs2_wilkinson_servo.sv
// Bench for irs2_wilkinson_servo: random TSTOUT waveforms against a window/edge-list model.
module tb_irs2_wilkinson_servo;

  localparam int G   = 1000;
  localparam int CLR = 16;
  localparam int P   = 2 * CLR + G + 1;

  logic        clk = 1'b0;
  logic        rst, enable, servo_en, vdly_load, tstout;
  logic [15:0] target, vdly_init, vdly, count;
  logic        tstclr, tstst, count_valid, busy;

  int compared   = 0;
  int mismatched = 0;

  // Model state: cyc = posedges seen; a window starts (CLEAR) after posedge s.
  int cyc     = 0;
  bit active  = 0;
  int s       = 0;
  int vdly_m  = 32'h8000;
  int cnt_o_m = 0;
  int cnt_m   = 0;
  int edges[$];
  int tgl     = 0;
  int h_lo    = 5;
  int h_hi    = 5;
  bit found;

  irs2_wilkinson_servo #(
    .GATE_CYCLES  (G),
    .CLR_CYCLES   (CLR),
    .VDLY_DEFAULT (16'h8000),
    .VDLY_STEP    (16'd16),
    .DEADBAND     (1)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .enable_i      (enable),
    .servo_en_i    (servo_en),
    .target_i      (target),
    .vdly_load_i   (vdly_load),
    .vdly_init_i   (vdly_init),
    .tstout_i      (tstout),
    .tstclr_o      (tstclr),
    .tstst_o       (tstst),
    .vdly_o        (vdly),
    .count_o       (count),
    .count_valid_o (count_valid),
    .busy_o        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int servo_model(input int v, input int c, input int t);
    if (c < t - 1) return (v + 16 > 65535) ? 65535 : v + 16;
    if (c > t + 1) return (v - 16 < 0) ? 0 : v - 16;
    return v;
  endfunction

  // One clock: advance the model from current inputs, clock, then compare all outputs.
  task automatic tick();
    bit upd;
    int n;
    int o;
    if (rst) begin
      active  = 0;
      vdly_m  = 32'h8000;
      cnt_o_m = 0;
    end else begin
      upd = active && (cyc == s + P - 1);
      if (vdly_load) vdly_m = int'(vdly_init);
      else if (upd && servo_en) vdly_m = servo_model(vdly_m, cnt_m, int'(target));
      if (active) begin
        if (!enable) active = 0;
        else if (upd) s += P;
      end else if (enable) begin
        active = 1;
        s      = cyc + 1;
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    // An edge driven before posedge k is counted at posedge k+2.
    if (active && (cyc == s + P - 1)) begin
      n = 0;
      foreach (edges[i]) if ((edges[i] + 2 >= cyc - G + 1) && (edges[i] + 2 <= cyc)) n++;
      cnt_m   = (n > 65535) ? 65535 : n;
      cnt_o_m = cnt_m;
      edges   = edges.find(x) with (x + 2 > cyc);
    end
    o = cyc - s;
    check("vdly", 32'(vdly), 32'(vdly_m));
    check("count", 32'(count), 32'(cnt_o_m));
    check("valid", 32'(count_valid), 32'(active && (o == P - 1)));
    check("busy", 32'(busy), 32'(active));
    check("tstclr", 32'(tstclr), 32'(!active || (o < CLR)));
    check("tstst", 32'(tstst), 32'(active && (o >= CLR) && (o < 2 * CLR)));
    if (tgl == 0) begin
      tstout = ~tstout;
      if (tstout) edges.push_back(cyc + 1);
      tgl = int'($urandom_range(h_hi, h_lo)) - 1;
    end else begin
      tgl--;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Bounded wait until the model reaches window offset off.
  task automatic wait_offset(input int off);
    found = 0;
    for (int i = 0; i < 2 * P + 4; i++) begin
      if (active && (cyc - s == off)) begin
        found = 1;
        break;
      end
      tick();
    end
    check("wait_offset", 32'(found), 32'd1);
  endtask

  initial begin
    rst       = 1'b1;
    enable    = 1'b0;
    servo_en  = 1'b0;
    target    = 16'd100;
    vdly_load = 1'b0;
    vdly_init = 16'h0;
    tstout    = 1'b0;
    run(3);
    rst = 1'b0;
    tick();

    // Count accuracy with jittered period around 10 clocks, servo off.
    h_lo = 4; h_hi = 6;
    enable = 1'b1;
    run(2 * P + 2);

    // Servo up, down and inside deadband with an exact 10-clock period.
    h_lo = 5; h_hi = 5;
    servo_en = 1'b1;
    target = 16'd120; run(2 * P);
    target = 16'd80;  run(2 * P);
    target = 16'd100; run(2 * P);

    // Saturation at both ends.
    vdly_init = 16'hFFF8; vdly_load = 1'b1; tick(); vdly_load = 1'b0;
    target = 16'hFFFF; run(2 * P);
    vdly_init = 16'h0008; vdly_load = 1'b1; tick(); vdly_load = 1'b0;
    target = 16'h0000; run(2 * P);

    // Random targets, servo enables and TSTOUT rates.
    repeat (3) begin
      target   = 16'($urandom_range(120, 80));
      servo_en = 1'($urandom_range(1, 0));
      h_lo     = int'($urandom_range(5, 1));
      h_hi     = h_lo + int'($urandom_range(3, 0));
      run(P);
    end

    // Load in the UPDATE cycle wins over a servo step.
    servo_en = 1'b1; target = 16'd500; h_lo = 5; h_hi = 5;
    wait_offset(P - 1);
    vdly_init = 16'h1234; vdly_load = 1'b1; tick(); vdly_load = 1'b0;
    check("load_priority", 32'(vdly), 32'h1234);
    run(P);

    // Abort mid-COUNT.
    wait_offset(2 * CLR + G / 2);
    enable = 1'b0;
    tick();
    check("abort_tstclr", 32'(tstclr), 32'd1);
    run(40);
    enable = 1'b1;

    // Reset in the middle of a window.
    wait_offset(2 * CLR + 100);
    rst = 1'b1; tick(); rst = 1'b0;
    check("midrst_vdly", 32'(vdly), 32'h8000);
    run(P + 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
